// File: rtl/hazard_stall_ctrl_if.sv
// Instruction inputs and hazard outputs shared between the pipeline and the
// stall controller.
interface hazard_stall_ctrl_if;
    logic [31:0] instrD;
    logic [31:0] instrE;
    logic [31:0] instrM;
    logic        stall;
    logic        flush_E;
    logic        mdu_start;
    logic        mdu_busy;
    logic [15:0] stall_cnt;

    modport master (
        output instrD, instrE, instrM,
        input  stall, flush_E, mdu_start, mdu_busy, stall_cnt
    );

    modport slave (
        input  instrD, instrE, instrM,
        output stall, flush_E, mdu_start, mdu_busy, stall_cnt
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Hazard scheduler: stalls F/D and bubbles D/E when forwarding cannot help,
// sequences the multi-cycle MDU and counts stall cycles.
module hazard_stall_ctrl #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    hazard_stall_ctrl_if.slave  bus
);

    typedef struct packed {
        logic cal_r;
        logic cal_i;
        logic load;
        logic store;
        logic beq;
        logic jr;
        logic jal;
        logic md;
        logic mf;
        logic mt;
    } dec_t;

    localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
    localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

    function automatic dec_t decode(input logic [5:0] op, input logic [5:0] fn);
        dec_t d;
        d = '0;
        if (op == 6'h00) begin
            case (fn)
                6'h20, 6'h21, 6'h22, 6'h23,
                6'h24, 6'h25, 6'h2a, 6'h2b: d.cal_r = 1'b1;
                6'h08:                      d.jr    = 1'b1;
                6'h18, 6'h19, 6'h1a, 6'h1b: d.md    = 1'b1;
                6'h10, 6'h12:               d.mf    = 1'b1;
                6'h11, 6'h13:               d.mt    = 1'b1;
                default: ;
            endcase
        end
        case (op)
            6'h0d, 6'h09, 6'h08, 6'h0f: d.cal_i = 1'b1;
            6'h23:                      d.load  = 1'b1;
            6'h2b:                      d.store = 1'b1;
            6'h04:                      d.beq   = 1'b1;
            6'h03:                      d.jal   = 1'b1;
            default: ;
        endcase
        return d;
    endfunction

    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    dec_t       dec_d, dec_e;
    logic       m_load;
    logic [4:0] rs_d, rt_d, rt_e, dest_e, rt_m;
    logic       e_writes, d_br, use1_rs, use1_rt;
    logic       s1, s2, s3, s4;
    logic       mdu_start, stall;

    // Fields never consulted by the scheduler (immediates, shamt, unused regs).
    logic unused_bits;
    assign unused_bits = ^{bus.instrD[15:6], bus.instrE[25:21], bus.instrE[10:6],
                           bus.instrM[25:21], bus.instrM[15:0]};

    always_comb begin
        dec_d     = decode(bus.instrD[31:26], bus.instrD[5:0]);
        dec_e     = decode(bus.instrE[31:26], bus.instrE[5:0]);
        m_load    = (bus.instrM[31:26] == 6'h23);
        rs_d      = bus.instrD[25:21];
        rt_d      = bus.instrD[20:16];
        rt_e      = bus.instrE[20:16];
        rt_m      = bus.instrM[20:16];
        dest_e    = dec_e.cal_r ? bus.instrE[15:11] : rt_e;
        // jal in E is forwarded, so only cal/load destinations matter here.
        e_writes  = (dec_e.cal_r | dec_e.cal_i | dec_e.load) && (dest_e != 5'd0);
        d_br      = dec_d.beq | dec_d.jr;
        use1_rs   = dec_d.cal_r | dec_d.cal_i | dec_d.load | dec_d.store | dec_d.md | dec_d.mt;
        use1_rt   = dec_d.cal_r | dec_d.md;
        mdu_start = dec_e.md;

        s1 = d_br && e_writes &&
             ((dest_e == rs_d) || (dec_d.beq && (dest_e == rt_d)));
        s2 = d_br && m_load && (rt_m != 5'd0) &&
             ((rt_m == rs_d) || (dec_d.beq && (rt_m == rt_d)));
        s3 = dec_e.load && (rt_e != 5'd0) &&
             ((use1_rs && (rs_d == rt_e)) || (use1_rt && (rt_d == rt_e)));
        s4 = (dec_d.md | dec_d.mf | dec_d.mt) && (mdu_start || (cnt_q != 4'd0));
        stall = s1 | s2 | s3 | s4;
    end

    always_comb begin
        cnt_d = cnt_q;
        // A new issue reloads even if the unit is still counting down.
        if (mdu_start) begin
            cnt_d = bus.instrE[1] ? DIV_LD : MULT_LD;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= 4'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall     = stall;
    assign bus.flush_E   = stall;
    assign bus.mdu_start = mdu_start;
    assign bus.mdu_busy  = (cnt_q != 4'd0);
    assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline hazard scheduler for the 5-stage MIPS core. It sits beside the forwarding units and decodes the instructions in D, E and M. When forwarding cannot supply an operand in time, it freezes PC and the F/D register and inserts a bubble into D/E. It also sequences the multi-cycle multiply/divide unit (MDU) with a busy down-counter and keeps a saturating stall-cycle counter for performance checks.

## Interface
- `MULT_CYC`, default 5: MDU busy cycles for mult/multu.
- `DIV_CYC`, default 10: MDU busy cycles for div/divu.
- `clk`  in  1  core clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instrD`  in  32  instruction in Decode.
- `instrE`  in  32  instruction in Execute.
- `instrM`  in  32  instruction in Memory.
- `stall`  out  1  hold PC and F/D register; combinational.
- `flush_E`  out  1  load NOP into D/E next edge; always equals `stall`.
- `mdu_start`  out  1  MDU operation issuing from E this cycle; combinational.
- `mdu_busy`  out  1  MDU counter nonzero; registered.
- `stall_cnt`  out  16  total stall cycles since reset; saturates at 0xFFFF.

## Operation
- **Local decode** (op = [31:26], funct = [5:0], rs = [25:21], rt = [20:16], rd = [15:11]):
  - cal_r: op 0 with funct addu/subu/add/sub/and/or/slt/sltu; writes rd.
  - cal_i: ori/addiu/addi/lui; writes rt.
  - load: lw (0x23); writes rt.
  - store: sw (0x2b).
  - beq: op 0x04.
  - jr: op 0, funct 0x08.
  - jal: op 0x03; writes 31.
  - md: funct 0x18–0x1b.
  - mf: mfhi/mflo. mt: mthi/mtlo.
  - Writes to register 0 never count as a hazard.
- **Operand use time**:
  - Tuse 0: beq rs/rt, jr rs.
  - Tuse 1: rs of cal_r, cal_i, load, store, md, mt; rt of cal_r, md.
  - Tuse 2: rt of store.
- **Stall terms** (stall is the OR of all):
  - S1: D is beq or jr, E is cal_r, cal_i or load, and E's destination equals a Tuse-0 source. jal in E is excluded because it is forwarded.
  - S2: D is beq or jr, M is load, and M's rt equals a Tuse-0 source.
  - S3: E is load and E's rt equals any Tuse-1 source of D.
  - S4: D is md, mf or mt, and (mdu_start or mdu_busy).
- `mdu_start` = E is md.
- **MDU counter** (`cnt`, 4 bits, registered):
  - When mdu_start is high, load MULT_CYC (funct 0x18/0x19) or DIV_CYC (funct 0x1a/0x1b).
  - Otherwise, if cnt ≠ 0, decrement by 1.
  - `mdu_busy` = (cnt ≠ 0).
- **Simultaneous events**:
  - mdu_start wins over decrement.
  - A second md in E while busy cannot occur, because S4 holds it in D. If it does occur, the counter reloads.
- **stall_cnt**: increments by 1 on each edge where stall = 1; holds at 0xFFFF.
- Undecoded instructions, including NOP (0x00000000), produce no hazard and no MDU activity.

## Timing
- **Reset** (`rst_n` = 0, asynchronous): cnt = 0, mdu_busy = 0, stall_cnt = 0.
  - stall, flush_E and mdu_start follow their inputs combinationally; with NOPs applied they are 0.
  - Reset asserted mid-MDU operation aborts it: mdu_busy is 0 immediately.
- **Latency**:
  - stall and mdu_start are zero-latency combinational from the instruction inputs.
  - mdu_busy rises on the edge after mdu_start and stays high for exactly MULT_CYC or DIV_CYC cycles.
- **Stall durations**:
  - Load-use (S3): exactly 1 cycle. After the bubble, the load sits in M and forwarding covers it.
  - beq/jr after cal (S1): 1 cycle.
  - beq/jr after load (S1 then S2): 2 cycles.
- **MDU stall**: md/mf/mt immediately behind a mult stalls 1 + MULT_CYC cycles. It is released in the cycle where cnt = 0.
- Parameters must fit 4 bits (≤ 15). Values outside 1..15 are unsupported.

## Test plan
- **lw/add load-use.** instrE = lw $8, instrD = addu $9, $8, $1 → stall = flush_E = 1 for 1 cycle; stall_cnt = 1.
- **lw/beq.** instrE = lw $8, instrD = beq $8, $0 → stall for 2 consecutive cycles (S1, then S2 after the bubble). Repeat with ori $8 in E → stall for 1 cycle.
- **jal/jr and $0 writes.** instrE = jal, instrD = jr $31 → stall = 0. instrE = addu $0, ..., instrD = beq $0, $0 → stall = 0.
- **mult then mflo.** mult in E, mflo in D → mdu_start = 1, then mdu_busy = 1 for 5 cycles, stall = 1 for 6 cycles total. Same with div → 11 cycles.
- **Reset mid-divide.** Pull rst_n low at cnt = 4 → mdu_busy = 0 and stall_cnt = 0 asynchronously. After release with NOPs, all outputs are 0.
- **Saturation.** Force 70000 stall cycles → stall_cnt holds at 0xFFFF.
